// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU port, the front-panel port, the arbiter and the RAM.
// The slave modport is the arbiter; the master modport is everything around it.
interface mem_port_arbiter_if #(
  parameter int AW = 16,
  parameter int DW = 8
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic [DW-1:0] cpu_rdata;

  logic          pnl_req;
  logic          pnl_we;
  logic [AW-1:0] pnl_addr;
  logic [DW-1:0] pnl_wdata;
  logic          pnl_ack;
  logic [DW-1:0] pnl_rdata;

  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_read;
  logic          ram_write;
  logic [DW-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  pnl_req, pnl_we, pnl_addr, pnl_wdata,
    output pnl_ack, pnl_rdata,
    output ram_addr, ram_wdata, ram_read, ram_write,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output pnl_req, pnl_we, pnl_addr, pnl_wdata,
    input  pnl_ack, pnl_rdata,
    input  ram_addr, ram_wdata, ram_read, ram_write,
    output ram_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main RAM between the CPU port and the front-panel port.
// Eligibility follows cpustate, ties are broken round-robin, and each access is
// a registered strobe / wait / ack sequence. All outputs come from flops.
module mem_port_arbiter #(
  parameter int AW  = 16,
  parameter int DW  = 8,
  parameter int ACC = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              cpustate,
  mem_port_arbiter_if.slave       bus,
  output logic [1:0]              owner,
  output logic                    busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_ACK    = 2'b10
  } state_t;

  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_CPU  = 2'b01;
  localparam logic [1:0] OWN_PNL  = 2'b10;
  localparam logic [3:0] ACC_LD   = 4'(ACC);

  state_t        state_r;
  logic [1:0]    owner_r;
  logic          busy_r;
  logic          we_r;
  logic [3:0]    wait_r;
  logic          rr_pnl_r;      // 1: panel is favoured on the next tie
  logic [AW-1:0] ram_addr_r;
  logic [DW-1:0] ram_wdata_r;
  logic          ram_read_r;
  logic          ram_write_r;
  logic          cpu_ack_r;
  logic          pnl_ack_r;
  logic [DW-1:0] cpu_rdata_r;
  logic [DW-1:0] pnl_rdata_r;

  logic          cpu_elig_s;
  logic          pnl_elig_s;
  logic          cpu_win_s;
  logic          pnl_win_s;

  // Which ports may be granted in the current cpustate.
  always_comb begin
    cpu_elig_s = 1'b0;
    pnl_elig_s = 1'b0;
    case (cpustate)
      2'b00:   begin cpu_elig_s = 1'b1; pnl_elig_s = 1'b1; end
      2'b01:   begin cpu_elig_s = 1'b1; pnl_elig_s = 1'b0; end
      2'b10:   begin cpu_elig_s = 1'b0; pnl_elig_s = 1'b1; end
      2'b11:   begin cpu_elig_s = 1'b0; pnl_elig_s = 1'b1; end
      default: begin cpu_elig_s = 1'b0; pnl_elig_s = 1'b0; end
    endcase
  end

  // Round-robin pick between the eligible, requesting ports.
  always_comb begin
    cpu_win_s = 1'b0;
    pnl_win_s = 1'b0;
    if (cpu_elig_s && bus.cpu_req && pnl_elig_s && bus.pnl_req) begin
      cpu_win_s = !rr_pnl_r;
      pnl_win_s = rr_pnl_r;
    end else begin
      cpu_win_s = cpu_elig_s && bus.cpu_req;
      pnl_win_s = pnl_elig_s && bus.pnl_req;
    end
  end

  // Transaction sequencer: grant, hold strobes for ACC+1 cycles, pulse ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      owner_r     <= OWN_NONE;
      busy_r      <= 1'b0;
      we_r        <= 1'b0;
      wait_r      <= 4'd0;
      rr_pnl_r    <= 1'b0;
      ram_addr_r  <= '0;
      ram_wdata_r <= '0;
      ram_read_r  <= 1'b0;
      ram_write_r <= 1'b0;
      cpu_ack_r   <= 1'b0;
      pnl_ack_r   <= 1'b0;
      cpu_rdata_r <= '0;
      pnl_rdata_r <= '0;
    end else begin
      cpu_ack_r <= 1'b0;
      pnl_ack_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cpu_win_s) begin
            owner_r     <= OWN_CPU;
            busy_r      <= 1'b1;
            we_r        <= bus.cpu_we;
            ram_addr_r  <= bus.cpu_addr;
            ram_wdata_r <= bus.cpu_wdata;
            ram_read_r  <= !bus.cpu_we;
            ram_write_r <= bus.cpu_we;
            wait_r      <= ACC_LD;
            state_r     <= ST_ACCESS;
          end else if (pnl_win_s) begin
            owner_r     <= OWN_PNL;
            busy_r      <= 1'b1;
            we_r        <= bus.pnl_we;
            ram_addr_r  <= bus.pnl_addr;
            ram_wdata_r <= bus.pnl_wdata;
            ram_read_r  <= !bus.pnl_we;
            ram_write_r <= bus.pnl_we;
            wait_r      <= ACC_LD;
            state_r     <= ST_ACCESS;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          if (wait_r == 4'd0) begin
            if (!we_r && owner_r == OWN_CPU) begin
              cpu_rdata_r <= bus.ram_rdata;
            end else if (!we_r && owner_r == OWN_PNL) begin
              pnl_rdata_r <= bus.ram_rdata;
            end else begin
              cpu_rdata_r <= cpu_rdata_r;
            end
            ram_read_r  <= 1'b0;
            ram_write_r <= 1'b0;
            cpu_ack_r   <= (owner_r == OWN_CPU);
            pnl_ack_r   <= (owner_r == OWN_PNL);
            state_r     <= ST_ACK;
          end else begin
            wait_r <= wait_r - 4'd1;
          end
        end
        ST_ACK: begin
          rr_pnl_r <= (owner_r == OWN_CPU);
          owner_r  <= OWN_NONE;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          owner_r     <= OWN_NONE;
          busy_r      <= 1'b0;
          ram_read_r  <= 1'b0;
          ram_write_r <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_wdata = ram_wdata_r;
  assign bus.ram_read  = ram_read_r;
  assign bus.ram_write = ram_write_r;
  assign bus.cpu_ack   = cpu_ack_r;
  assign bus.pnl_ack   = pnl_ack_r;
  assign bus.cpu_rdata = cpu_rdata_r;
  assign bus.pnl_rdata = pnl_rdata_r;
  assign owner         = owner_r;
  assign busy          = busy_r;

endmodule
